paint_column_scheduler: RTL and testbench

Sequences LED column output for the light painter from quadrature-decoded encoder motion. It consumes the single-cycle step/direction strobes produced by the encoder decoding path, converts net forward travel into column boundaries, and issues one column request per boundary to the LED strip driver over a req/ack handshake. It tracks a full stroke from arm to last column, then reports completion and flags any column dropped because the driver was still busy.

---
 rtl/paint_column_scheduler.sv | 130 +++++++++++++
 tb/tb_paint_column_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_column_scheduler.sv
// paint_column_scheduler
// Turns decoded encoder step/direction strobes into LED column requests for the
// light painter. Net forward travel is accumulated into column boundaries. Each
// boundary hands one column to the strip driver over a req/ack handshake. A
// stroke runs from arm to the acknowledgement of its last column.

module paint_column_scheduler #(
    parameter int NUM_COLS      = 32,
    parameter int STEPS_PER_COL = 4,
    localparam int CW           = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          dir,
    input  logic          arm,
    input  logic          col_ack,
    output logic          col_req,
    output logic [CW-1:0] col_idx,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int AW = (STEPS_PER_COL > 1) ? $clog2(STEPS_PER_COL) : 1;
    // The next-column counter has one spare bit so that it can hold NUM_COLS,
    // which means "every column of this stroke has been handed out".
    localparam int NW = CW + 1;
    localparam logic [AW-1:0] ACC_LAST = AW'(STEPS_PER_COL - 1);
    localparam logic [NW-1:0] COL_END  = NW'(NUM_COLS);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PAINT
    } state_t;

    state_t         state;
    logic [AW-1:0]  acc;
    logic [NW-1:0]  next_col;

    logic fwd;
    logic rev;
    logic cols_left;
    logic boundary;
    logic ack_taken;

    // Decode the step strobe and detect column boundaries and accepted acks.
    always_comb begin
        fwd       = step & dir;
        rev       = step & ~dir;
        cols_left = (next_col != COL_END);
        boundary  = (state == PAINT) && fwd && (acc == ACC_LAST) && cols_left;
        ack_taken = col_req & col_ack;
    end

    // Stroke sequencer: the state, the step accumulator and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            next_col <= '0;
            col_req  <= 1'b0;
            col_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= ARMED;
                        busy     <= 1'b1;
                        acc      <= '0;
                        next_col <= '0;
                        overrun  <= 1'b0;
                    end
                end

                ARMED: begin
                    if (fwd) begin
                        state    <= PAINT;
                        col_req  <= 1'b1;
                        col_idx  <= '0;
                        acc      <= '0;
                        next_col <= NW'(1);
                    end
                end

                PAINT: begin
                    // Once the last column has been handed out, steps no longer matter.
                    if (cols_left) begin
                        if (fwd) begin
                            acc <= (acc == ACC_LAST) ? '0 : acc + 1'b1;
                        end else if (rev && (acc != '0)) begin
                            acc <= acc - 1'b1;
                        end
                    end

                    if (boundary) begin
                        next_col <= next_col + 1'b1;
                        if (!col_req || col_ack) begin
                            col_req <= 1'b1;
                            col_idx <= next_col[CW-1:0];
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (ack_taken) begin
                        col_req <= 1'b0;
                        // The stroke ends when the final outstanding request is acked.
                        // This normally means the ack of column NUM_COLS-1. If that
                        // column was lost to an overrun, the stroke still terminates
                        // instead of waiting forever.
                        if (!cols_left) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_column_scheduler.sv
// tb_paint_column_scheduler
// Directed bench for paint_column_scheduler with NUM_COLS=4 and STEPS_PER_COL=3.
// Stimulus pushes each expected column request or done pulse onto a queue. A
// negedge monitor pops that queue whenever the DUT presents a new request or a
// done pulse. Direct level checks cover reset, overrun, busy and the quiet cases.

module tb_paint_column_scheduler;

    localparam int NUM_COLS      = 4;
    localparam int STEPS_PER_COL = 3;
    localparam int CW            = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          step;
    logic          dir;
    logic          arm;
    logic          col_ack;
    logic          col_req;
    logic [CW-1:0] col_idx;
    logic          busy;
    logic          done;
    logic          overrun;

    typedef struct packed {
        logic          is_done;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic last_req   = 1'b0;
    logic last_taken = 1'b0;

    paint_column_scheduler #(
        .NUM_COLS      (NUM_COLS),
        .STEPS_PER_COL (STEPS_PER_COL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .dir     (dir),
        .arm     (arm),
        .col_ack (col_ack),
        .col_req (col_req),
        .col_idx (col_idx),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one clock cycle of inputs, 3 units after the rising edge.
    task automatic applyStimulus(input logic s, input logic d, input logic a,
                                 input logic k);
        @(posedge clk);
        #3;
        step    = s;
        dir     = d;
        arm     = a;
        col_ack = k;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fwdStep();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic revStep();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ackPulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic armPulse();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pushReq(input logic [CW-1:0] idx);
        exp_q.push_back('{is_done: 1'b0, idx: idx});
    endtask

    task automatic pushDone();
        exp_q.push_back('{is_done: 1'b1, idx: '0});
    endtask

    // Hold reset for one sampling edge. On return, outputs reflect that edge.
    task automatic pulseReset();
        @(posedge clk);
        #3;
        reset   = 1'b1;
        step    = 1'b0;
        dir     = 1'b0;
        arm     = 1'b0;
        col_ack = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // Monitor: a new request is col_req high after being low or after an accepted ack.
    always @(negedge clk) begin
        exp_t e;
        if ((col_req === 1'b1) && (!last_req || last_taken)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_req: got col %0d expected none", col_idx);
            end else begin
                e = exp_q.pop_front();
                checkOutput("req_event", {29'd0, 1'b0, col_idx}, {29'd0, e.is_done, e.idx});
            end
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done 1 expected none");
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_event", {29'd0, 1'b1, 2'b00}, {29'd0, e.is_done, e.idx});
            end
        end
        last_req   = (col_req === 1'b1);
        last_taken = (col_req === 1'b1) && (col_ack === 1'b1);
    end

    initial begin
        logic bnd;
        reset   = 1'b1;
        step    = 1'b0;
        dir     = 1'b0;
        arm     = 1'b0;
        col_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        checkOutput("rst_col_req", col_req, 0);
        checkOutput("rst_col_idx", col_idx, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_overrun", overrun, 0);

        $display("[TB] nominal stroke");
        armPulse();
        idle();
        checkOutput("nom_busy_after_arm", busy, 1);
        for (int i = 1; i <= 11; i++) begin
            bnd = (i == 1) || (i == 4) || (i == 7) || (i == 10);
            if (bnd) pushReq(CW'((i - 1) / 3));
            if (i == 10) pushDone();
            fwdStep();
            idle();
            applyStimulus(1'b0, 1'b0, 1'b0, bnd);
            idle();
            if (i == 10) begin
                checkOutput("nom_done_pulse", done, 1);
                checkOutput("nom_busy_at_done", busy, 0);
            end
        end
        checkOutput("nom_done_cleared", done, 0);
        checkOutput("nom_overrun", overrun, 0);
        checkOutput("nom_req_idle", col_req, 0);

        $display("[TB] reverse handling");
        pulseReset();
        armPulse();
        repeat (5) revStep();
        idle();
        idle();
        checkOutput("rev_armed_no_req", col_req, 0);
        checkOutput("rev_armed_busy", busy, 1);
        pushReq(0);
        fwdStep();
        ackPulse();
        idle();
        fwdStep();
        fwdStep();
        revStep();
        revStep();
        revStep();
        fwdStep();
        fwdStep();
        idle();
        idle();
        checkOutput("rev_no_boundary", col_req, 0);
        pushReq(1);
        fwdStep();
        idle();
        checkOutput("rev_col1_req", col_req, 1);
        checkOutput("rev_col1_idx", col_idx, 1);
        ackPulse();
        idle();
        checkOutput("rev_col1_acked", col_req, 0);

        $display("[TB] overrun");
        pulseReset();
        armPulse();
        pushReq(0);
        fwdStep();
        fwdStep();
        fwdStep();
        fwdStep();
        checkOutput("ovr_before", overrun, 0);
        fwdStep();
        checkOutput("ovr_rise", overrun, 1);
        checkOutput("ovr_req_held", col_req, 1);
        checkOutput("ovr_idx_held", col_idx, 0);
        fwdStep();
        fwdStep();
        idle();
        checkOutput("ovr_idx_after7", col_idx, 0);
        ackPulse();
        idle();
        checkOutput("ovr_acked", col_req, 0);
        pushReq(3);
        fwdStep();
        fwdStep();
        fwdStep();
        idle();
        checkOutput("ovr_col3_idx", col_idx, 3);
        pushDone();
        ackPulse();
        idle();
        checkOutput("ovr_done", done, 1);
        checkOutput("ovr_sticky", overrun, 1);
        armPulse();
        idle();
        checkOutput("ovr_cleared_by_arm", overrun, 0);
        checkOutput("ovr_rearm_busy", busy, 1);

        $display("[TB] coincident ack and boundary");
        pushReq(0);
        fwdStep();
        idle();
        ackPulse();
        idle();
        fwdStep();
        fwdStep();
        pushReq(1);
        fwdStep();
        idle();
        fwdStep();
        fwdStep();
        pushReq(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        checkOutput("coin_req", col_req, 1);
        checkOutput("coin_idx", col_idx, 2);
        checkOutput("coin_overrun", overrun, 0);
        ackPulse();
        idle();

        $display("[TB] reset mid-stroke");
        pulseReset();
        armPulse();
        pushReq(0);
        fwdStep();
        idle();
        ackPulse();
        idle();
        fwdStep();
        fwdStep();
        pushReq(1);
        fwdStep();
        idle();
        fwdStep();
        fwdStep();
        fwdStep();
        idle();
        checkOutput("mid_pre_overrun", overrun, 1);
        checkOutput("mid_pre_idx", col_idx, 1);
        pulseReset();
        checkOutput("mid_rst_req", col_req, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_idx", col_idx, 0);
        checkOutput("mid_rst_overrun", overrun, 0);
        repeat (4) fwdStep();
        idle();
        checkOutput("idle_steps_req", col_req, 0);
        checkOutput("idle_steps_busy", busy, 0);

        $display("[TB] arm during paint and back-to-back strokes");
        armPulse();
        idle();
        pushReq(0);
        fwdStep();
        idle();
        ackPulse();
        idle();
        fwdStep();
        fwdStep();
        armPulse();
        idle();
        checkOutput("paint_arm_busy", busy, 1);
        pushReq(1);
        fwdStep();
        idle();
        checkOutput("paint_arm_req", col_req, 1);
        checkOutput("paint_arm_idx", col_idx, 1);
        ackPulse();
        idle();
        pushReq(2);
        fwdStep();
        fwdStep();
        fwdStep();
        idle();
        ackPulse();
        idle();
        pushReq(3);
        pushDone();
        fwdStep();
        fwdStep();
        fwdStep();
        idle();
        ackPulse();
        armPulse();
        checkOutput("b2b_done", done, 1);
        idle();
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_done_low", done, 0);
        pushReq(0);
        fwdStep();
        idle();
        checkOutput("b2b_req", col_req, 1);
        checkOutput("b2b_idx", col_idx, 0);
        pulseReset();

        repeat (3) idle();
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
